// File: rtl/dbus_sram_responder.sv
// Data-bus responder: single-outstanding request, fixed latency,
// byte-strobed writes and full-word reads on a 64-bit SRAM array.
module dbus_sram_responder #(
    parameter int unsigned DEPTH   = 4096,
    parameter int unsigned LATENCY = 2,
    parameter logic [63:0] BASE    = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dreq_valid,
    input  logic [63:0] dreq_addr,
    input  logic [2:0]  dreq_size,
    input  logic [7:0]  dreq_strobe,
    input  logic [63:0] dreq_data,
    output logic        dresp_addr_ok,
    output logic        dresp_data_ok,
    output logic [63:0] dresp_data,
    output logic        oob_err,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [63:0] SPAN = 64'(DEPTH) << 3;
    localparam logic [3:0]  LAT4 = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        addr_ok_q, addr_ok_d;
    logic        data_ok_q, data_ok_d;
    logic [63:0] data_q, data_d;
    logic        oob_q, oob_d;
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    logic [63:0] mem [DEPTH];

    logic [63:0]   off;
    logic          in_range;
    logic [AW-1:0] idx;
    logic          is_wr;
    logic          go;
    logic          size_unused;

    assign off         = dreq_addr - BASE;
    assign in_range    = off < SPAN;
    assign idx         = off[AW+2:3];
    assign is_wr       = |dreq_strobe;
    assign size_unused = ^dreq_size;

    // go marks the edge that enters RESP; the array access happens there
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_ok_d = 1'b0;
        data_ok_d = 1'b0;
        data_d    = data_q;
        oob_d     = oob_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        go        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (dreq_valid) begin
                    if (LATENCY == 0) begin
                        go = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT4;
                    end
                end
            end
            WAIT: begin
                if (!dreq_valid) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd1) begin
                    go = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (go) begin
            state_d   = RESP;
            addr_ok_d = 1'b1;
            data_ok_d = 1'b1;
            data_d    = (in_range && !is_wr) ? mem[idx] : 64'd0;
            if (!in_range) begin
                oob_d = 1'b1;
            end
            if (is_wr) begin
                wr_cnt_d = wr_cnt_q + 32'd1;
            end else begin
                rd_cnt_d = rd_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_ok_q <= 1'b0;
            data_ok_q <= 1'b0;
            data_q    <= 64'd0;
            oob_q     <= 1'b0;
            rd_cnt_q  <= 32'd0;
            wr_cnt_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_ok_q <= addr_ok_d;
            data_ok_q <= data_ok_d;
            data_q    <= data_d;
            oob_q     <= oob_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    // Array is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (go && in_range && is_wr) begin
            for (int i = 0; i < 8; i++) begin
                if (dreq_strobe[i]) begin
                    mem[idx][8*i +: 8] <= dreq_data[8*i +: 8];
                end
            end
        end
    end

    assign dresp_addr_ok = addr_ok_q;
    assign dresp_data_ok = data_ok_q;
    assign dresp_data    = data_q;
    assign oob_err       = oob_q;
    assign rd_cnt        = rd_cnt_q;
    assign wr_cnt        = wr_cnt_q;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed bench for dbus_sram_responder: one LATENCY=2 instance,
// one LATENCY=0 instance for back-to-back requests.
module tb_dbus_sram_responder;

    localparam logic [63:0] BASE = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        va = 1'b0, vb = 1'b0;
    logic [63:0] aa = '0, ab = '0;
    logic [7:0]  sa = '0, sb = '0;
    logic [63:0] da = '0, db = '0;

    logic        aok_a, dok_a, oob_a;
    logic [63:0] rdat_a;
    logic [31:0] rc_a, wc_a;
    logic        aok_b, dok_b, oob_b;
    logic [63:0] rdat_b;
    logic [31:0] rc_b, wc_b;

    int n_chk = 0;
    int n_err = 0;
    int pulses_a = 0;
    int pulses_b = 0;

    always #5 clk = ~clk;

    dbus_sram_responder #(
        .DEPTH(4096), .LATENCY(2), .BASE(BASE)
    ) u_a (
        .clk(clk), .reset(reset),
        .dreq_valid(va), .dreq_addr(aa), .dreq_size(3'd3),
        .dreq_strobe(sa), .dreq_data(da),
        .dresp_addr_ok(aok_a), .dresp_data_ok(dok_a),
        .dresp_data(rdat_a), .oob_err(oob_a),
        .rd_cnt(rc_a), .wr_cnt(wc_a)
    );

    dbus_sram_responder #(
        .DEPTH(16), .LATENCY(0), .BASE(BASE)
    ) u_b (
        .clk(clk), .reset(reset),
        .dreq_valid(vb), .dreq_addr(ab), .dreq_size(3'd3),
        .dreq_strobe(sb), .dreq_data(db),
        .dresp_addr_ok(aok_b), .dresp_data_ok(dok_b),
        .dresp_data(rdat_b), .oob_err(oob_b),
        .rd_cnt(rc_b), .wr_cnt(wc_b)
    );

    always @(posedge clk) begin
        if (dok_a) pulses_a++;
        if (dok_b) pulses_b++;
    end

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request, hold it until data_ok, check the response
    task automatic run(input string tag, input bit b,
                       input logic [63:0] addr, input logic [7:0] strb,
                       input logic [63:0] wdata, input logic [63:0] exp,
                       input int exp_lat);
        int lat;
        logic aok;
        logic [63:0] rd;
        @(negedge clk);
        if (b) begin
            ab = addr; sb = strb; db = wdata; vb = 1'b1;
        end else begin
            aa = addr; sa = strb; da = wdata; va = 1'b1;
        end
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (b ? dok_b : dok_a) begin
                lat = i;
                break;
            end
        end
        aok = b ? aok_b : aok_a;
        rd  = b ? rdat_b : rdat_a;
        @(negedge clk);
        if (b) vb = 1'b0;
        else   va = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, ".addr_ok"}, 64'(aok), 64'd1);
        chk({tag, ".data"}, rd, exp);
        chk({tag, ".pulse1"}, 64'(b ? dok_b : dok_a), 64'd0);
    endtask

    initial begin
        int p0;
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
        p0 = 0;
    end

    initial begin
        int p0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.dok", 64'(dok_a), 64'd0);
        chk("rst.aok", 64'(aok_a), 64'd0);
        chk("rst.data", rdat_a, 64'd0);
        chk("rst.oob", 64'(oob_a), 64'd0);
        chk("rst.cnt", {rc_a, wc_a}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run("wr0", 0, 64'h8000_0010, 8'hFF,
            64'h1122_3344_5566_7788, 64'd0, 3);
        chk("wr0.wc", 64'(wc_a), 64'd1);
        run("rd0", 0, 64'h8000_0010, 8'h00, 64'd0,
            64'h1122_3344_5566_7788, 3);
        chk("rd0.rc", 64'(rc_a), 64'd1);
        run("wrp", 0, 64'h8000_0010, 8'h0C,
            64'h0000_0000_AABB_0000, 64'd0, 3);
        run("rdp", 0, 64'h8000_0010, 8'h00, 64'd0,
            64'h1122_3344_AABB_7788, 3);

        run("wlo", 0, 64'h8000_0000, 8'hFF,
            64'hCAFE_F00D_DEAD_BEEF, 64'd0, 3);
        run("whi", 0, 64'h8000_7FF8, 8'hFF,
            64'h0123_4567_89AB_CDEF, 64'd0, 3);
        chk("pre.oob", 64'(oob_a), 64'd0);
        run("oobr", 0, 64'h7FFF_FFF8, 8'h00, 64'd0, 64'd0, 3);
        chk("oobr.flag", 64'(oob_a), 64'd1);
        chk("oobr.rc", 64'(rc_a), 64'd3);
        run("oobw", 0, 64'h8000_8000, 8'hFF,
            64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 3);
        chk("oobw.wc", 64'(wc_a), 64'd5);
        run("rlo", 0, 64'h8000_0000, 8'h00, 64'd0,
            64'hCAFE_F00D_DEAD_BEEF, 3);
        run("rhi", 0, 64'h8000_7FF8, 8'h00, 64'd0,
            64'h0123_4567_89AB_CDEF, 3);
        chk("oob.sticky", 64'(oob_a), 64'd1);

        // Abandon a write while waiting
        p0 = pulses_a;
        @(negedge clk);
        aa = 64'h8000_0010; sa = 8'hFF;
        da = 64'hDEAD_DEAD_DEAD_DEAD; va = 1'b1;
        @(posedge clk);
        @(negedge clk);
        va = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("abn.pulses", 64'(pulses_a), 64'(p0));
        chk("abn.cnt", {rc_a, wc_a}, {32'd5, 32'd5});

        // Reset in the middle of a wait
        @(negedge clk);
        va = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        va = 1'b0;
        #1;
        chk("mrst.dok", 64'(dok_a), 64'd0);
        chk("mrst.aok", 64'(aok_a), 64'd0);
        chk("mrst.data", rdat_a, 64'd0);
        chk("mrst.oob", 64'(oob_a), 64'd0);
        chk("mrst.cnt", {rc_a, wc_a}, 64'd0);
        @(posedge clk);
        #1;
        chk("mrst.dok2", 64'(dok_a), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("mrst.pulses", 64'(pulses_a), 64'(p0));
        run("rpost", 0, 64'h8000_0010, 8'h00, 64'd0,
            64'h1122_3344_AABB_7788, 3);
        chk("rpost.cnt", {rc_a, wc_a}, {32'd1, 32'd0});

        // Zero-latency instance, valid held across two reads
        run("bw1", 1, 64'h8000_0008, 8'hFF,
            64'hA1A1_A1A1_0000_0001, 64'd0, 1);
        run("bw2", 1, 64'h8000_0010, 8'hFF,
            64'hB2B2_B2B2_0000_0002, 64'd0, 1);
        p0 = pulses_b;
        @(negedge clk);
        ab = 64'h8000_0008; sb = 8'h00; vb = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b.dok1", 64'(dok_b), 64'd1);
        chk("b2b.d1", rdat_b, 64'hA1A1_A1A1_0000_0001);
        @(negedge clk);
        ab = 64'h8000_0010;
        @(posedge clk);
        #1;
        chk("b2b.gap", 64'(dok_b), 64'd0);
        @(posedge clk);
        #1;
        chk("b2b.dok2", 64'(dok_b), 64'd1);
        chk("b2b.d2", rdat_b, 64'hB2B2_B2B2_0000_0002);
        @(negedge clk);
        vb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("b2b.pulses", 64'(pulses_b), 64'(p0 + 2));
        chk("b2b.rc", 64'(rc_b), 64'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dbus_sram_responder.md
Name: dbus_sram_responder

Overview:
- Data-bus responder on the far end of the core's dbus request/response interface.
- Accepts one request at a time and models a fixed, parameterisable access latency.
- Performs byte-strobed writes and full-word reads against an internal 64-bit-wide SRAM array.
- Returns the addr_ok/data_ok handshake the core's memory stage waits on. It serves as the simulation data memory and as the template for the later cache-backed responder.

Parameters:
- DEPTH, 4096, number of 64-bit words in the array; power of two, at least 2.
- LATENCY, 2, wait cycles between accepting a request and the response cycle; range 0..15.
- BASE, 64'h8000_0000, byte address of word 0.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- dreq_valid  in  1  request present; the requester holds all request fields stable until it sees data_ok.
- dreq_addr  in  64  byte address.
- dreq_size  in  3  msize code: 0=1B, 1=2B, 2=4B, 3=8B. Informational only.
- dreq_strobe  in  8  byte write enables. All zero means a read.
- dreq_data  in  64  write data, lane-aligned: byte i sits in bits [8i+7:8i].
- dresp_addr_ok  out  1  request accepted; pulses together with data_ok.
- dresp_data_ok  out  1  response valid, one-cycle pulse.
- dresp_data  out  64  read data, the whole aligned word.
- oob_err  out  1  sticky flag: an out-of-range access occurred.
- rd_cnt  out  32  completed read count.
- wr_cnt  out  32  completed write count.

Behaviour:
- Reset, asynchronous and active-low:
  - FSM goes to IDLE; wait counter clears.
  - dresp_addr_ok, dresp_data_ok, dresp_data, oob_err, rd_cnt and wr_cnt all clear to 0.
  - Array contents are not reset.
- Address decode:
  - off = dreq_addr - BASE (64-bit subtract).
  - The access is in range when off < DEPTH*8.
  - Word index = off[log2(DEPTH)+2:3]. Bits [2:0] are ignored; the requester places data on the correct lanes via strobe.
- States: IDLE, WAIT, RESP.
  - IDLE: if dreq_valid=1, go to WAIT with cnt=LATENCY, or go directly to RESP when LATENCY=0. Otherwise stay in IDLE.
  - WAIT:
    - If dreq_valid drops, the request is abandoned: return to IDLE with no memory or counter side effects.
    - Else if cnt==1, go to RESP.
    - Else decrement cnt.
  - RESP:
    - The registered outputs dresp_addr_ok=1, dresp_data_ok=1 and dresp_data are visible in this state, exactly one cycle.
    - The array access happens on the edge that enters RESP, using the request fields sampled on that edge.
    - Next state is always IDLE.
- Cycle timing: a request first seen high in IDLE at cycle t gets data_ok in cycle t+LATENCY+1. Total occupancy is LATENCY+2 cycles per access.
- Back-to-back: after RESP the FSM is in IDLE. If dreq_valid is still high there, that is a new request, because the requester has advanced after data_ok. There is no combinational path from dreq to dresp.
- Write (strobe != 0):
  - For each i with strobe[i]=1, mem[idx] byte i is replaced by dreq_data byte i. Other bytes are unchanged.
  - dresp_data returns 0.
  - wr_cnt increments by 1.
- Read (strobe == 0): dresp_data = mem[idx], the pre-existing contents. rd_cnt increments by 1.
- Out-of-range access: still completes the full handshake with identical timing. No write occurs, dresp_data = 0, oob_err sets to 1 and stays set until reset. The read/write counter still increments.
- Counters wrap modulo 2^32.
- Reset asserted mid-WAIT or mid-RESP: the FSM returns to IDLE immediately. Any data_ok pulse in progress is cut off; no partial write occurs unless the write edge has already passed.
- dresp_data is held at its last value outside RESP. Consumers qualify it with data_ok.

Test Plan:
- Reset, then write addr=0x8000_0010, strobe=0xFF, data=0x1122334455667788, LATENCY=2 -> data_ok high exactly in cycle t+3 for one cycle; addr_ok coincident; wr_cnt=1.
- Read 0x8000_0010 -> dresp_data=0x1122334455667788 at data_ok; rd_cnt=1.
- Partial write strobe=0x0C, data=0x00000000AABB0000 to 0x8000_0010, then read -> 0x11223344AABB7788.
- Hold dreq_valid high over two consecutive different reads (LATENCY=0) -> data_ok pulses 2 cycles apart, each with the correct word; no extra pulse.
- Read at 0x7FFF_FFF8, then write at BASE+DEPTH*8 -> both complete with data 0; oob_err=1 after the first; array unchanged; rd_cnt and wr_cnt each increment.
- Drop dreq_valid during WAIT, then assert reset mid-WAIT on a second request -> no data_ok, no memory change, counters unchanged; all outputs 0 while reset is low.
